// File: rtl/sarray_drain_deskew.sv
// ============================================================================
// Module   : sarray_drain_deskew
// Brief    : Re-aligns skewed systolic-array result rows, validates them and
//            buffers them in a show-ahead FIFO with a valid/ready drain port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sarray_drain_deskew #(
  parameter int SARRAY_W   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SARRAY_W-1:0]              si_valid_i,
  input  logic [CNT_WIDTH*SARRAY_W-1:0]    si_cnt_i,
  input  logic [DATA_WIDTH*SARRAY_W-1:0]   si_data_i,
  output logic                             do_valid_o,
  input  logic                             do_ready_i,
  output logic [CNT_WIDTH-1:0]             do_cnt_o,
  output logic [DATA_WIDTH*SARRAY_W-1:0]   do_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_free_o,
  output logic                             err_skew_o,
  output logic                             err_ovf_o
);

  localparam int c_FREE_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_ROW_W  = DATA_WIDTH * SARRAY_W;

  logic [SARRAY_W-1:0]   w_al_valid;
  logic [CNT_WIDTH-1:0]  w_al_cnt  [SARRAY_W];
  logic [DATA_WIDTH-1:0] w_al_data [SARRAY_W];

  // Column c waits SARRAY_W-c cycles so every column of a row lands together.
  for (genvar c = 0; c < SARRAY_W; c++) begin : g_col
    localparam int c_DLY = SARRAY_W - c;
    logic                  r_v [c_DLY];
    logic [CNT_WIDTH-1:0]  r_c [c_DLY];
    logic [DATA_WIDTH-1:0] r_d [c_DLY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < c_DLY; i++) r_v[i] <= 1'b0;
      end else begin
        r_v[0] <= si_valid_i[c];
        for (int i = 1; i < c_DLY; i++) r_v[i] <= r_v[i-1];
      end
      r_c[0] <= si_cnt_i[c*CNT_WIDTH +: CNT_WIDTH];
      r_d[0] <= si_data_i[c*DATA_WIDTH +: DATA_WIDTH];
      for (int i = 1; i < c_DLY; i++) begin
        r_c[i] <= r_c[i-1];
        r_d[i] <= r_d[i-1];
      end
    end

    assign w_al_valid[c] = r_v[c_DLY-1];
    assign w_al_cnt[c]   = r_c[c_DLY-1];
    assign w_al_data[c]  = r_d[c_DLY-1];
  end

  logic               w_cnt_ok;
  logic [c_ROW_W-1:0] w_row;
  logic               w_push;
  logic               w_skew;

  always_comb begin
    w_cnt_ok = 1'b1;
    w_row    = '0;
    for (int c = 0; c < SARRAY_W; c++) begin
      if (w_al_cnt[c] != w_al_cnt[0]) w_cnt_ok = 1'b0;
      w_row[c*DATA_WIDTH +: DATA_WIDTH] = w_al_data[c];
    end
  end

  assign w_push = (&w_al_valid) & w_cnt_ok;
  assign w_skew = (|w_al_valid) & ~w_push;

  logic [CNT_WIDTH-1:0] r_mem_cnt  [FIFO_DEPTH];
  logic [c_ROW_W-1:0]   r_mem_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_FREE_W-1:0]  r_count;
  logic [c_FREE_W-1:0]  r_free;
  logic [c_FREE_W-1:0]  w_count_nxt;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  logic                 w_drop;
  logic                 r_err_skew;
  logic                 r_err_ovf;

  function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FREE_W'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & do_ready_i;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_free     <= c_FREE_W'(FIFO_DEPTH);
      r_err_skew <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      if (w_wr)   r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      r_count <= w_count_nxt;
      r_free  <= c_FREE_W'(FIFO_DEPTH) - w_count_nxt;
      if (w_skew) r_err_skew <= 1'b1;
      if (w_drop) r_err_ovf  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      r_mem_cnt[r_wr_ptr]  <= w_al_cnt[0];
      r_mem_data[r_wr_ptr] <= w_row;
    end
  end

  assign do_valid_o  = ~w_empty;
  assign do_cnt_o    = w_empty ? '0 : r_mem_cnt[r_rd_ptr];
  assign do_data_o   = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign fifo_free_o = r_free;
  assign err_skew_o  = r_err_skew;
  assign err_ovf_o   = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sarray_drain_deskew.sv
// ============================================================================
// Module   : tb_sarray_drain_deskew
// Brief    : Directed scoreboard bench for sarray_drain_deskew.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sarray_drain_deskew;

  localparam int c_W  = 4;
  localparam int c_DW = 32;
  localparam int c_CW = 4;
  localparam int c_FD = 4;
  localparam int c_EW = c_CW + c_DW * c_W;

  logic                  clk;
  logic                  rst;
  logic [c_W-1:0]        si_valid_i;
  logic [c_CW*c_W-1:0]   si_cnt_i;
  logic [c_DW*c_W-1:0]   si_data_i;
  logic                  do_valid_o;
  logic                  do_ready_i;
  logic [c_CW-1:0]       do_cnt_o;
  logic [c_DW*c_W-1:0]   do_data_o;
  logic [2:0]            fifo_free_o;
  logic                  err_skew_o;
  logic                  err_ovf_o;

  sarray_drain_deskew #(
    .SARRAY_W(c_W), .DATA_WIDTH(c_DW), .CNT_WIDTH(c_CW), .FIFO_DEPTH(c_FD)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .si_valid_i (si_valid_i),
    .si_cnt_i   (si_cnt_i),
    .si_data_i  (si_data_i),
    .do_valid_o (do_valid_o),
    .do_ready_i (do_ready_i),
    .do_cnt_o   (do_cnt_o),
    .do_data_o  (do_data_o),
    .fifo_free_o(fifo_free_o),
    .err_skew_o (err_skew_o),
    .err_ovf_o  (err_ovf_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  logic [c_EW-1:0] exp_q[$];

  // Row stimulus table; per-row valid mask and an optional bad tag on one column.
  int              nrows;
  logic [c_CW-1:0] row_cnt  [8];
  logic [c_W-1:0]  row_mask [8];
  int              row_badc [8];
  logic [c_CW-1:0] row_badv [8];
  logic [c_DW-1:0] row_base [8];

  task automatic check(input string name, input logic [c_EW-1:0] act, input logic [c_EW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_row(input logic [c_CW-1:0] cnt, input logic [c_DW-1:0] base,
                         input logic [c_W-1:0] mask, input int badc,
                         input logic [c_CW-1:0] badv, input bit expect_out);
    logic [c_EW-1:0] e;
    row_cnt[nrows]  = cnt;
    row_base[nrows] = base;
    row_mask[nrows] = mask;
    row_badc[nrows] = badc;
    row_badv[nrows] = badv;
    nrows++;
    if (expect_out) begin
      e = '0;
      e[c_EW-1 -: c_CW] = cnt;
      for (int c = 0; c < c_W; c++) e[c*c_DW +: c_DW] = base + c_DW'(c);
      exp_q.push_back(e);
    end
  endtask

  // Drives the table skewed: column c of row r in cycle r+c.
  task automatic send_rows();
    for (int k = 0; k < nrows + c_W - 1; k++) begin
      si_valid_i = '0;
      si_cnt_i   = '0;
      si_data_i  = '0;
      for (int c = 0; c < c_W; c++) begin
        int r;
        r = k - c;
        if (r >= 0 && r < nrows && row_mask[r][c]) begin
          si_valid_i[c] = 1'b1;
          si_cnt_i[c*c_CW +: c_CW] = (row_badc[r] == c) ? row_badv[r] : row_cnt[r];
          si_data_i[c*c_DW +: c_DW] = row_base[r] + c_DW'(c);
        end
      end
      tick();
    end
    si_valid_i = '0;
    si_cnt_i   = '0;
    si_data_i  = '0;
    nrows = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  // Monitor: every handshake pops the oldest expected row.
  always @(negedge clk) begin
    if (!rst && do_valid_o && do_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_row: got cnt=%0h data=%0h required none", do_cnt_o, do_data_o);
      end else begin
        check("row_out", {do_cnt_o, do_data_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int first_v;
    int vcount;
    int min_free;
    rst = 1'b1;
    do_ready_i = 1'b0;
    si_valid_i = '0;
    si_cnt_i   = '0;
    si_data_i  = '0;
    nrows = 0;
    do_reset();

    @(negedge clk);
    check("rst_valid", c_EW'(do_valid_o), '0);
    check("rst_cnt", c_EW'(do_cnt_o), '0);
    check("rst_data", c_EW'(do_data_o), '0);
    check("rst_free", c_EW'(fifo_free_o), c_EW'(4));
    check("rst_errs", c_EW'({err_skew_o, err_ovf_o}), '0);
    tick();

    // 1: single row latency and content
    do_ready_i = 1'b1;
    add_row(4'd3, 32'h100, 4'hF, -1, 4'd0, 1'b1);
    first_v = -1;
    fork
      send_rows();
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (do_valid_o && first_v < 0) first_v = i;
        end
      end
    join
    check("t1_latency", c_EW'(first_v), c_EW'(5));
    check("t1_errs", c_EW'({err_skew_o, err_ovf_o}), '0);
    check("t1_drained", c_EW'(exp_q.size()), '0);

    // 2: four rows back-to-back with ready held high
    do_reset();
    for (int r = 0; r < 4; r++) add_row(4'(r), 32'h200 + 32'(r * 16), 4'hF, -1, 4'd0, 1'b1);
    vcount = 0;
    min_free = 4;
    fork
      send_rows();
      begin
        for (int i = 0; i < 14; i++) begin
          @(negedge clk);
          if (do_valid_o) vcount++;
          if (int'(fifo_free_o) < min_free) min_free = int'(fifo_free_o);
        end
      end
    join
    check("t2_valid_cycles", c_EW'(vcount), c_EW'(4));
    check("t2_min_free", c_EW'(min_free), c_EW'(3));
    check("t2_drained", c_EW'(exp_q.size()), '0);

    // 3: overflow with ready low, fifth row lost
    do_reset();
    do_ready_i = 1'b0;
    for (int r = 0; r < 5; r++) add_row(4'(r), 32'h300 + 32'(r * 16), 4'hF, -1, 4'd0, r < 4);
    send_rows();
    settle(3);
    @(negedge clk);
    check("t3_free_full", c_EW'(fifo_free_o), '0);
    check("t3_ovf", c_EW'(err_ovf_o), c_EW'(1));
    check("t3_head_cnt", c_EW'(do_cnt_o), '0);
    tick();
    do_ready_i = 1'b1;
    settle(6);
    @(negedge clk);
    check("t3_free_back", c_EW'(fifo_free_o), c_EW'(4));
    check("t3_drained", c_EW'(exp_q.size()), '0);

    // 4: full FIFO, push and pop in the same cycle
    do_reset();
    do_ready_i = 1'b0;
    for (int r = 0; r < 4; r++) add_row(4'(r), 32'h400 + 32'(r * 16), 4'hF, -1, 4'd0, 1'b1);
    send_rows();
    settle(3);
    add_row(4'd4, 32'h440, 4'hF, -1, 4'd0, 1'b1);
    fork
      send_rows();
      begin
        settle(c_W);
        do_ready_i = 1'b1;
        tick();
        do_ready_i = 1'b0;
      end
    join
    @(negedge clk);
    check("t4_free", c_EW'(fifo_free_o), '0);
    check("t4_ovf", c_EW'(err_ovf_o), '0);
    check("t4_head_cnt", c_EW'(do_cnt_o), c_EW'(1));
    tick();
    do_ready_i = 1'b1;
    settle(6);
    check("t4_drained", c_EW'(exp_q.size()), '0);

    // 5: missing column, tag mismatch, then a good row
    do_reset();
    add_row(4'd3, 32'h500, 4'b1011, -1, 4'd0, 1'b0);
    add_row(4'd3, 32'h510, 4'hF, 1, 4'd5, 1'b0);
    add_row(4'd6, 32'h520, 4'hF, -1, 4'd0, 1'b1);
    send_rows();
    settle(4);
    @(negedge clk);
    check("t5_skew", c_EW'(err_skew_o), c_EW'(1));
    check("t5_ovf", c_EW'(err_ovf_o), '0);
    check("t5_drained", c_EW'(exp_q.size()), '0);
    tick();

    // 6: reset while a row is in flight
    do_reset();
    si_valid_i = 4'b0001; si_cnt_i = 16'h0003; si_data_i = '0; si_data_i[31:0] = 32'h600;
    tick();
    si_valid_i = 4'b0010; si_cnt_i = 16'h0030; si_data_i = '0; si_data_i[63:32] = 32'h601;
    tick();
    si_valid_i = 4'b0100; si_cnt_i = 16'h0300; si_data_i = '0; si_data_i[95:64] = 32'h602;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    si_valid_i = '0; si_cnt_i = '0; si_data_i = '0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (do_valid_o) vcount++;
    end
    check("t6_no_valid", c_EW'(vcount), '0);
    check("t6_free", c_EW'(fifo_free_o), c_EW'(4));
    check("t6_errs", c_EW'({err_skew_o, err_ovf_o}), '0);
    tick();
    add_row(4'd9, 32'h700, 4'hF, -1, 4'd0, 1'b1);
    send_rows();
    settle(4);
    check("t6_after_drained", c_EW'(exp_q.size()), '0);
    check("t6_after_errs", c_EW'({err_skew_o, err_ovf_o}), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
